// File: rtl/coin_acceptor_if.sv
// Coin acceptor bus: raw coin lines, user/vend controls in; credit, pulses and refund out.
interface coin_acceptor_if #(
  parameter int unsigned N_COIN   = 4,
  parameter int unsigned CREDIT_W = 8
);
  logic [N_COIN-1:0]   coin_in;
  logic                cancel_btn;
  logic [CREDIT_W-1:0] price;
  logic                vend_done;
  logic [N_COIN-1:0]   coin_pulse;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                enough_payment;
  logic                o_cancel;
  logic                refund_valid;
  logic [CREDIT_W-1:0] refund_amount;

  modport master (
    output coin_in, cancel_btn, price, vend_done,
    input  coin_pulse, coin_reject, credit, enough_payment, o_cancel, refund_valid, refund_amount
  );

  modport slave (
    input  coin_in, cancel_btn, price, vend_done,
    output coin_pulse, coin_reject, credit, enough_payment, o_cancel, refund_valid, refund_amount
  );
endinterface

// File: rtl/coin_acceptor_n.sv
// N-denomination coin acceptor: synchronises coin lines, accumulates credit, rejects and refunds.
// Optional input debounce is enabled by defining COIN_DEBOUNCE_EN.
module coin_acceptor_n #(
  parameter int unsigned                       N_COIN       = 4,
  parameter int unsigned                       CREDIT_W     = 8,
  parameter logic [N_COIN*CREDIT_W-1:0]        COIN_VALUES  = {8'd20, 8'd10, 8'd5, 8'd1},
  parameter int unsigned                       DEBOUNCE_CYC = 4
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             m_rst,
  coin_acceptor_if.slave   bus
);

  localparam int unsigned SUM_W = CREDIT_W + 1;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    CANCEL   = 2'd2
  } state_t;

  if (DEBOUNCE_CYC == 0) begin : g_bad_debounce
    $error("coin_acceptor_n: DEBOUNCE_CYC must be at least 1");
  end

  state_t              state_q, state_d;
  logic [N_COIN-1:0]   sync1_q, cs_q;
  logic [1:0]          prime_q;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] refund_amt_q, refund_amt_d;
  logic [N_COIN-1:0]   pulse_q, pulse_d;
  logic                reject_q, reject_d;
  logic                refund_valid_q, refund_valid_d;
  logic                enough_q, enough_d;
  logic                cancel_q, cancel_d;
  logic                cwait_q, cwait_d;

  logic                rst_c;
  logic                any_c, one_c, lines_low_c, stable_c, vend_ok_c;
  logic [CREDIT_W-1:0] value_c;
  logic [SUM_W-1:0]    sum_c;

  assign rst_c = i_rst | m_rst;
  assign any_c = |cs_q;
  assign one_c = $onehot(cs_q);
  // Reset clears the synchroniser, so "all low" only counts once it holds post-reset samples.
  assign lines_low_c = ~any_c & prime_q[1];

  // Value of the asserted channel (only meaningful when exactly one line is high)
  always_comb begin : coin_value
    value_c = '0;
    for (int i = 0; i < int'(N_COIN); i++) begin
      if (cs_q[i]) value_c = value_c | COIN_VALUES[i*CREDIT_W +: CREDIT_W];
    end
  end

  assign sum_c     = SUM_W'(credit_q) + SUM_W'(value_c);
  assign vend_ok_c = (bus.price != '0) && (credit_q >= bus.price);

`ifdef COIN_DEBOUNCE_EN
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC) + 1;

  logic [N_COIN-1:0] cs_prev_q;
  logic [CNT_W-1:0]  stab_cnt_q;

  // Counts consecutive cycles the synchronised lines have held their value
  always_ff @(posedge clk) begin : debounce
    if (rst_c) begin
      cs_prev_q  <= '0;
      stab_cnt_q <= '0;
    end else begin
      cs_prev_q <= cs_q;
      if (cs_q != cs_prev_q)                             stab_cnt_q <= '0;
      else if (stab_cnt_q < CNT_W'(DEBOUNCE_CYC - 1))    stab_cnt_q <= stab_cnt_q + CNT_W'(1);
    end
  end

  assign stable_c = (cs_q == cs_prev_q) && (stab_cnt_q >= CNT_W'(DEBOUNCE_CYC - 1));
`else
  assign stable_c = 1'b1;
`endif

  always_comb begin : fsm_next
    state_d        = state_q;
    credit_d       = credit_q;
    refund_amt_d   = refund_amt_q;
    pulse_d        = '0;
    reject_d       = 1'b0;
    refund_valid_d = 1'b0;
    cwait_d        = cwait_q;
    enough_d       = vend_ok_c;

    case (state_q)
      WAIT_LOW: begin
        if (lines_low_c && stable_c) state_d = IDLE;
      end

      IDLE: begin
        if (bus.cancel_btn) begin
          refund_amt_d   = credit_q;
          refund_valid_d = 1'b1;
          credit_d       = '0;
          cwait_d        = 1'b0;
          state_d        = CANCEL;
        end else if (bus.vend_done) begin
          // A coin present now stays on the lines and is evaluated next cycle
          if (vend_ok_c) credit_d = credit_q - bus.price;
        end else if (any_c && stable_c) begin
          if (one_c && !enough_q && !sum_c[CREDIT_W]) begin
            credit_d = sum_c[CREDIT_W-1:0];
            pulse_d  = cs_q;
          end else begin
            reject_d = 1'b1;
          end
          state_d = WAIT_LOW;
        end
      end

      CANCEL: begin
        // Same one-event-per-insertion tracking as WAIT_LOW, but every coin is returned
        if (cwait_q) begin
          if (lines_low_c && stable_c) cwait_d = 1'b0;
        end else if (any_c && stable_c) begin
          reject_d = 1'b1;
          cwait_d  = 1'b1;
        end
      end

      default: state_d = WAIT_LOW;
    endcase

    cancel_d = (state_d == CANCEL);
  end

  always_ff @(posedge clk) begin : regs
    if (rst_c) begin
      state_q        <= WAIT_LOW;
      sync1_q        <= '0;
      cs_q           <= '0;
      prime_q        <= '0;
      credit_q       <= '0;
      refund_amt_q   <= '0;
      pulse_q        <= '0;
      reject_q       <= 1'b0;
      refund_valid_q <= 1'b0;
      enough_q       <= 1'b0;
      cancel_q       <= 1'b0;
      cwait_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync1_q        <= bus.coin_in;
      cs_q           <= sync1_q;
      prime_q        <= {prime_q[0], 1'b1};
      credit_q       <= credit_d;
      refund_amt_q   <= refund_amt_d;
      pulse_q        <= pulse_d;
      reject_q       <= reject_d;
      refund_valid_q <= refund_valid_d;
      enough_q       <= enough_d;
      cancel_q       <= cancel_d;
      cwait_q        <= cwait_d;
    end
  end

  assign bus.coin_pulse     = pulse_q;
  assign bus.coin_reject    = reject_q;
  assign bus.credit         = credit_q;
  assign bus.enough_payment = enough_q;
  assign bus.o_cancel       = cancel_q;
  assign bus.refund_valid   = refund_valid_q;
  assign bus.refund_amount  = refund_amt_q;

endmodule
